// File: rtl/fetch_unit.sv
// fetch_unit: PC plus req/ack instruction fetch feeding the IR, with a bounded memory wait that raises a sticky fault.
module fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int INSTR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               next,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               ir_w_en,
    output logic [INSTR_W-1:0] ir_d_in,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               fault
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, EXEC} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    assign mem_addr = pc;
    assign busy = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc <= RESET_PC;
            mem_req <= 1'b0;
            ir_w_en <= 1'b0;
            ir_d_in <= '0;
            fault <= 1'b0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (run && !fault) begin
                    state <= FETCH;
                    mem_req <= 1'b1;
                    cnt <= '0;
                end
                FETCH: if (mem_ack) begin
                    ir_d_in <= mem_rdata;
                    ir_w_en <= 1'b1;
                    mem_req <= 1'b0;
                    pc <= pc + 1'b1;
                    state <= ISSUE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    // the final unanswered request cycle: give up and latch the fault
                    fault <= 1'b1;
                    mem_req <= 1'b0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                ISSUE: begin
                    ir_w_en <= 1'b0;
                    state <= EXEC;
                end
                EXEC: if (next) begin
                    pc <= jump ? jump_target : pc;
                    mem_req <= run;
                    cnt <= '0;
                    state <= run ? FETCH : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven cycle vectors plus directed sequences for wait states, async reset and timeout.
module tb_fetch_unit;
    logic clk = 1'b0, rst = 1'b1, run = 1'b0, next = 1'b0, jump = 1'b0;
    logic [7:0] jump_target = '0;
    logic mem_req, mem_ack, ir_w_en, busy, fault;
    logic [7:0] mem_addr, pc;
    logic [15:0] mem_rdata, ir_d_in;
    logic mem_en = 1'b1;
    int ack_delay = 0;
    int wait_cnt = 0;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .run(run), .next(next), .jump(jump), .jump_target(jump_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_w_en(ir_w_en), .ir_d_in(ir_d_in), .pc(pc), .busy(busy), .fault(fault)
    );

    // memory model: answers ack_delay cycles after the request rises, data = A000 + address
    always @(posedge clk) wait_cnt <= mem_req ? wait_cnt + 1 : 0;
    assign mem_ack = mem_en && mem_req && (wait_cnt == ack_delay);
    assign mem_rdata = 16'hA000 + {8'h00, mem_addr};

    typedef struct {
        logic run, nxt, jmp;
        logic [7:0] tgt;
        logic req, wen;
        logic [15:0] din;
        logic [7:0] pc;
        logic busy;
    } vec_t;
    vec_t vq[$];

    function automatic vec_t mk(logic r, logic n, logic j, logic [7:0] t,
                                logic q, logic w, logic [15:0] d, logic [7:0] p, logic b);
        vec_t x;
        x.run = r; x.nxt = n; x.jmp = j; x.tgt = t;
        x.req = q; x.wen = w; x.din = d; x.pc = p; x.busy = b;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int reqs, pulses;
        logic [7:0] addr0;
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b1));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'hA000, 8'h01, 1'b1));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'hA000, 8'h01, 1'b1));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'hA000, 8'h01, 1'b1));
        vq.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'hA000, 8'h01, 1'b1));
        vq.push_back(mk(1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 16'hA001, 8'h02, 1'b1));
        vq.push_back(mk(1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 16'hA001, 8'h02, 1'b1));
        vq.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'hA001, 8'h02, 1'b1));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'hA002, 8'h03, 1'b1));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'hA002, 8'h03, 1'b1));
        vq.push_back(mk(1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 16'hA002, 8'h40, 1'b1));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'hA040, 8'h41, 1'b1));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'hA040, 8'h41, 1'b1));
        vq.push_back(mk(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 16'hA040, 8'hFF, 1'b1));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'hA0FF, 8'h00, 1'b1));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'hA0FF, 8'h00, 1'b1));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'hA0FF, 8'h00, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'hA0FF, 8'h00, 1'b0));

        // reset state, then idle with run low
        #12;
        chk("rst_pc", pc, 8'h00);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_din", ir_d_in, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        step();
        for (int i = 0; i < 10; i++) chk("idle_no_req", mem_req, 1'b0);

        // cycle vectors: sequential fetch, ignored next, jump, wrap, stop
        foreach (vq[i]) begin
            run = vq[i].run; next = vq[i].nxt; jump = vq[i].jmp; jump_target = vq[i].tgt;
            step();
            chk($sformatf("v%0d_req", i), mem_req, vq[i].req);
            chk($sformatf("v%0d_wen", i), ir_w_en, vq[i].wen);
            chk($sformatf("v%0d_din", i), ir_d_in, vq[i].din);
            chk($sformatf("v%0d_pc", i), pc, vq[i].pc);
            chk($sformatf("v%0d_addr", i), mem_addr, vq[i].pc);
            chk($sformatf("v%0d_busy", i), busy, vq[i].busy);
        end
        next = 1'b0; jump = 1'b0;

        // wait states: ack three cycles late
        ack_delay = 3;
        run = 1'b1;
        reqs = 0;
        addr0 = mem_addr;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_req) begin
                reqs++;
                chk("ws_addr_stable", mem_addr, addr0);
            end
            if (ir_w_en) break;
        end
        chk("ws_req_cycles", reqs, 4);
        chk("ws_wen", ir_w_en, 1'b1);
        chk("ws_din", ir_d_in, 16'hA000);
        chk("ws_pc", pc, 8'h01);
        step();
        chk("ws_wen_single", ir_w_en, 1'b0);
        chk("ws_no_fault", fault, 1'b0);
        next = 1'b1; run = 1'b0;
        step();
        next = 1'b0;
        chk("ws_back_idle", busy, 1'b0);
        ack_delay = 0;

        // asynchronous reset in the middle of a fetch
        mem_en = 1'b0;
        run = 1'b1;
        step();
        step();
        chk("mid_req_high", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_req", mem_req, 1'b0);
        chk("async_wen", ir_w_en, 1'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_pc", pc, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // timeout: no ack ever
        reqs = 0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mem_req) reqs++;
            if (ir_w_en) pulses++;
            if (fault) break;
        end
        chk("to_fault", fault, 1'b1);
        chk("to_req_cycles", reqs, 15);
        chk("to_no_wen", pulses, 0);
        chk("to_req_low", mem_req, 1'b0);
        chk("to_idle", busy, 1'b0);
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (mem_req) reqs++;
        end
        chk("to_blocked", reqs, 0);
        chk("to_sticky", fault, 1'b1);
        run = 1'b0;
        rst = 1'b1;
        #1;
        chk("to_cleared", fault, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mem_en = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
